// File: rtl/noise_sfx_sequencer.sv
// Purpose: shell/explosion noise sequencer. Turns sound-register trigger edges into
//          two decaying 4-bit envelopes gated by the noise bits, and drives noise shift/clear.
// Latency: trigger edge -> busy/level 1 clk_en tick; level -> gated output 1 further tick.
// Backpressure: none; all state advances only on clk_en ticks (noise_en is a 1-clk pulse).
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   clk_en                    sound-domain tick enable
//   sound_enable              master enable; low forces both channels idle and clears the shifters
//   shell_trig/shell_loud     shell trigger level and start-level select (1 -> 15, 0 -> 8)
//   explo_trig/explo_loud     explosion trigger level and start-level select
//   shell_noise/explo_noise   noise bits from the shifters
//   noise_en                  one-clk shift enable to the shifters
//   noise_rst                 hold-clear to the shifters
//   shell_out/explo_out       gated 4-bit amplitudes
//   busy                      {explo active, shell active}
module noise_sfx_sequencer #(
    parameter int NOISE_DIV = 12,
    parameter int DECAY_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       sound_enable,
    input  logic       shell_trig,
    input  logic       shell_loud,
    input  logic       explo_trig,
    input  logic       explo_loud,
    input  logic       shell_noise,
    input  logic       explo_noise,
    output logic       noise_en,
    output logic       noise_rst,
    output logic [3:0] shell_out,
    output logic [3:0] explo_out,
    output logic [1:0] busy
);

    localparam int PW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam int NW = (NOISE_DIV > 1) ? $clog2(NOISE_DIV) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DECAY = 1'b1
    } state_t;

    // Channel 0 = shell, channel 1 = explosion.
    logic [1:0] w_trig;
    logic [1:0] w_loud;
    logic [1:0] w_active;
    logic [7:0] w_level_all;

    assign w_trig = {explo_trig, shell_trig};
    assign w_loud = {explo_loud, shell_loud};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t          r_state;
        state_t          w_state_nxt;
        logic [3:0]      r_level;
        logic [3:0]      w_level_nxt;
        logic [PW-1:0]   r_presc;
        logic [PW-1:0]   w_presc_nxt;
        logic            r_trig_d;
        logic            w_edge;

        assign w_edge = w_trig[c] & ~r_trig_d;

        // Priority per tick: disable > trigger edge > decay step. The edge beating
        // the decay step means a retrigger on the prescaler wrap reloads without
        // also decrementing.
        always_comb begin
            w_state_nxt = r_state;
            w_level_nxt = r_level;
            w_presc_nxt = r_presc;
            if (clk_en) begin
                if (!sound_enable) begin
                    w_state_nxt = ST_IDLE;
                    w_level_nxt = 4'd0;
                    w_presc_nxt = '0;
                end else if (w_edge) begin
                    w_state_nxt = ST_DECAY;
                    w_level_nxt = w_loud[c] ? 4'd15 : 4'd8;
                    w_presc_nxt = '0;
                end else if (r_state == ST_DECAY) begin
                    if (r_presc == PW'(DECAY_DIV - 1)) begin
                        w_presc_nxt = '0;
                        w_level_nxt = r_level - 4'd1;
                        if (r_level == 4'd1) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state  <= ST_IDLE;
                r_level  <= 4'd0;
                r_presc  <= '0;
                r_trig_d <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_level <= w_level_nxt;
                r_presc <= w_presc_nxt;
                // Tracks the trigger even while disabled so a held trigger
                // cannot fire when sound is re-enabled.
                if (clk_en) begin
                    r_trig_d <= w_trig[c];
                end
            end
        end

        assign w_active[c]          = (r_state == ST_DECAY);
        assign w_level_all[c*4 +: 4] = r_level;
    end

    // Noise divider: runs only while an effect is active so the first shift
    // after an idle period lands exactly NOISE_DIV ticks after the load.
    logic [NW-1:0] r_div;
    logic [NW-1:0] w_div_nxt;
    logic          w_noise_pulse;
    logic          r_noise_en;
    logic          r_noise_rst;
    logic [3:0]    r_shell_out;
    logic [3:0]    r_explo_out;

    always_comb begin
        w_div_nxt     = r_div;
        w_noise_pulse = 1'b0;
        if (clk_en) begin
            if (w_active == 2'b00) begin
                w_div_nxt = '0;
            end else if (r_div == NW'(NOISE_DIV - 1)) begin
                w_div_nxt     = '0;
                w_noise_pulse = 1'b1;
            end else begin
                w_div_nxt = r_div + NW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_noise_en  <= 1'b0;
            r_noise_rst <= 1'b1;
            r_shell_out <= 4'd0;
            r_explo_out <= 4'd0;
        end else begin
            r_div      <= w_div_nxt;
            // Written every clk so the pulse is one clk wide even when clk_en is slow.
            r_noise_en <= w_noise_pulse;
            if (clk_en) begin
                r_noise_rst <= ~sound_enable;
                r_shell_out <= shell_noise ? w_level_all[3:0] : 4'd0;
                r_explo_out <= explo_noise ? w_level_all[7:4] : 4'd0;
            end
        end
    end

    assign noise_en  = r_noise_en;
    assign noise_rst = r_noise_rst;
    assign shell_out = r_shell_out;
    assign explo_out = r_explo_out;
    assign busy      = w_active;

endmodule

// File: tb/tb_noise_sfx_sequencer.sv
// Purpose: directed self-checking bench for noise_sfx_sequencer (NOISE_DIV=4, DECAY_DIV=8).
// Latency: inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Backpressure: n/a; stimulus is a fixed linear sequence of steps.
module tb_noise_sfx_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       sound_enable;
    logic       shell_trig;
    logic       shell_loud;
    logic       explo_trig;
    logic       explo_loud;
    logic       shell_noise;
    logic       explo_noise;
    logic       noise_en;
    logic       noise_rst;
    logic [3:0] shell_out;
    logic [3:0] explo_out;
    logic [1:0] busy;

    int n_cmp  = 0;
    int n_fail = 0;

    noise_sfx_sequencer #(
        .NOISE_DIV(4),
        .DECAY_DIV(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .sound_enable (sound_enable),
        .shell_trig   (shell_trig),
        .shell_loud   (shell_loud),
        .explo_trig   (explo_trig),
        .explo_loud   (explo_loud),
        .shell_noise  (shell_noise),
        .explo_noise  (explo_noise),
        .noise_en     (noise_en),
        .noise_rst    (noise_rst),
        .shell_out    (shell_out),
        .explo_out    (explo_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        clk_en       = 1'b1;
        sound_enable = 1'b0;
        shell_trig   = 1'b0;
        shell_loud   = 1'b0;
        explo_trig   = 1'b0;
        explo_loud   = 1'b0;
        shell_noise  = 1'b0;
        explo_noise  = 1'b0;

        // Reset state
        step(3);
        chk("rst_noise_rst", 8'(noise_rst), 8'd1);
        chk("rst_shell_out", 8'(shell_out), 8'd0);
        chk("rst_explo_out", 8'(explo_out), 8'd0);
        chk("rst_busy",      8'(busy),      8'd0);
        chk("rst_noise_en",  8'(noise_en),  8'd0);
        rst          = 1'b0;
        sound_enable = 1'b1;
        step(1);
        chk("rel_noise_rst", 8'(noise_rst), 8'd0);

        // Loud shell decay: load edge is k=0
        shell_noise = 1'b1;
        shell_loud  = 1'b1;
        shell_trig  = 1'b1;
        step(1);
        chk("load_busy",  8'(busy),      8'd1);
        chk("load_out0",  8'(shell_out), 8'd0);
        step(1);
        chk("load_out15", 8'(shell_out), 8'd15);
        for (int k = 2; k <= 121; k++) begin
            step(1);
            if (k % 8 == 1) begin
                chk("decay_out", 8'(shell_out), 8'(15 - (k - 1) / 8));
            end
            chk("decay_busy",  8'(busy),     (k < 120) ? 8'd1 : 8'd0);
            chk("decay_noise", 8'(noise_en), ((k % 4 == 0) && (k <= 120)) ? 8'd1 : 8'd0);
            chk("decay_explo", 8'(explo_out), 8'd0);
        end

        // Retrigger at level 3 with soft select
        shell_trig = 1'b0;
        step(1);
        shell_trig = 1'b1;
        step(1);                       // load, k'=0
        step(97);
        chk("lvl3_out", 8'(shell_out), 8'd3);
        shell_loud = 1'b0;
        shell_trig = 1'b0;
        step(1);
        shell_trig = 1'b1;
        step(1);                       // reload at R
        chk("retrig_busy", 8'(busy), 8'd1);
        step(1);
        chk("retrig_out8", 8'(shell_out), 8'd8);

        // Edge on prescaler wrap (R+8) reloads, no decrement
        shell_trig = 1'b0;
        step(6);                       // R+7
        shell_loud = 1'b1;
        shell_trig = 1'b1;
        step(1);                       // R+8
        step(1);
        chk("wrap_out15", 8'(shell_out), 8'd15);
        step(7);
        chk("wrap_hold15", 8'(shell_out), 8'd15);
        step(1);
        chk("wrap_dec14", 8'(shell_out), 8'd14);

        // Disable at level 10, trigger held high
        step(32);
        chk("dis_lvl10", 8'(shell_out), 8'd10);
        sound_enable = 1'b0;
        step(1);
        chk("dis_busy",      8'(busy),      8'd0);
        chk("dis_noise_rst", 8'(noise_rst), 8'd1);
        step(1);
        chk("dis_out0", 8'(shell_out), 8'd0);
        sound_enable = 1'b1;
        step(2);
        chk("reen_busy",      8'(busy),      8'd0);
        chk("reen_noise_rst", 8'(noise_rst), 8'd0);
        chk("reen_out0",      8'(shell_out), 8'd0);

        // Simultaneous edges
        shell_trig = 1'b0;
        explo_trig = 1'b0;
        step(1);
        shell_loud  = 1'b0;
        explo_loud  = 1'b1;
        explo_noise = 1'b1;
        shell_trig  = 1'b1;
        explo_trig  = 1'b1;
        step(1);
        chk("sim_busy", 8'(busy), 8'd3);
        step(1);
        chk("sim_shell8",  8'(shell_out), 8'd8);
        chk("sim_explo15", 8'(explo_out), 8'd15);

        // Clear, then explosion noise gating
        sound_enable = 1'b0;
        shell_trig   = 1'b0;
        explo_trig   = 1'b0;
        step(1);
        sound_enable = 1'b1;
        step(1);
        explo_loud = 1'b0;
        explo_trig = 1'b1;
        step(1);                       // load 8
        for (int i = 1; i <= 6; i++) begin
            explo_noise = i[0];
            step(1);
            chk("gate_explo", 8'(explo_out), i[0] ? 8'd8 : 8'd0);
            chk("gate_shell", 8'(shell_out), 8'd0);
        end

        // Clear, then clk_en every 3rd clk
        sound_enable = 1'b0;
        explo_trig   = 1'b0;
        step(1);
        sound_enable = 1'b1;
        step(1);
        shell_loud = 1'b1;
        shell_trig = 1'b1;
        clk_en     = 1'b1;
        step(1);                       // enabled edge: load
        chk("gclk_busy", 8'(busy), 8'd1);
        clk_en = 1'b0;
        step(2);
        for (int m = 1; m <= 9; m++) begin
            clk_en = 1'b1;
            step(1);
            chk("gclk_noise_on", 8'(noise_en),  (m % 4 == 0) ? 8'd1 : 8'd0);
            chk("gclk_out",      8'(shell_out), (m == 9) ? 8'd14 : 8'd15);
            clk_en = 1'b0;
            step(1);
            chk("gclk_noise_off", 8'(noise_en),  8'd0);
            chk("gclk_out_hold",  8'(shell_out), (m == 9) ? 8'd14 : 8'd15);
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/noise_sfx_sequencer.md
# noise_sfx_sequencer

Sequences the shared noise shift-register pair that produces the shell and explosion noise sources, one block upstream of the sound mixer. It generates the noise shift enable and clear for the shifters. It turns CPU sound-register triggers into two independent decaying amplitude envelopes. Each envelope is gated by its noise bit to form 4-bit shell and explosion outputs.

## Interface
Parameters:
- NOISE_DIV, 12: clk_en ticks per noise shift pulse (≥2).
- DECAY_DIV, 1024: clk_en ticks per envelope decrement (≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  sound-domain tick; all state except reset advances only when high.
- sound_enable  in  1  master sound enable from sound register.
- shell_trig  in  1  shell trigger level from sound register; rising edge starts envelope.
- shell_loud  in  1  shell start level select: 1 → 15, 0 → 8.
- explo_trig  in  1  explosion trigger level; rising edge starts envelope.
- explo_loud  in  1  explosion start level select: 1 → 15, 0 → 8.
- shell_noise  in  1  shell noise bit from shifters.
- explo_noise  in  1  explosion noise bit from shifters.
- noise_en  out  1  one-cycle shift enable to shifters.
- noise_rst  out  1  hold-clear to shifters.
- shell_out  out  4  gated shell amplitude.
- explo_out  out  4  gated explosion amplitude.
- busy  out  2  {explo active, shell active}.

## Operation
- Per channel FSM, two states: IDLE (level=0), DECAY (level>0).
- Edge detect: trig sampled into trig_d on every clk_en cycle. Edge = trig & !trig_d on a clk_en cycle.
- Edge in either state while sound_enable=1:
  - level ← 15 or 8 per *_loud.
  - channel prescaler ← 0.
  - state ← DECAY.
  - A retrigger mid-decay reloads unconditionally, even to a lower level.
- DECAY: prescaler counts clk_en ticks 0..DECAY_DIV-1.
  - On wrap: level decrements.
  - Level reaching 0 → IDLE.
  - An edge on the wrap cycle wins: reload, no decrement.
- sound_enable=0: both channels forced to IDLE, levels 0, prescalers 0. Triggers are ignored but trig_d keeps tracking, so a held trigger does not fire when enable returns.
- Noise divider counts clk_en ticks only while any channel is in DECAY.
  - noise_en=1 for exactly one clk on the clk_en cycle where the divider equals NOISE_DIV-1; the divider then wraps to 0.
  - Divider cleared to 0 when both channels are IDLE.
- noise_rst = !sound_enable, registered. The shifters are cleared while sound is disabled and otherwise keep running between effects.
- Outputs are registered:
  - shell_out ← shell_noise ? shell_level : 0.
  - explo_out ← explo_noise ? explo_level : 0.
- Both channels are fully independent. Simultaneous edges load both in the same cycle.

## Timing
- Reset values: levels 0, states IDLE, prescalers 0, divider 0, trig_d 0, noise_en 0, noise_rst 1, shell_out 0, explo_out 0, busy 2'b00.
- Reset mid-effect: all outputs take reset values on the next clk edge, regardless of clk_en.
- Trigger latency:
  - Edge on clk_en cycle N → level loaded and busy bit set at edge N+1.
  - Output reflects the new level at N+2.
- Decay: after a load, the first decrement occurs on the DECAY_DIV-th subsequent clk_en tick. Loud envelope lasts 15·DECAY_DIV ticks to IDLE; soft lasts 8·DECAY_DIV.
- First noise_en after leaving all-idle comes NOISE_DIV clk_en ticks after the load.
- clk_en low: nothing changes except noise_en, which stays 0.
- noise_rst follows sound_enable with 1 clk latency.

## Test plan
- Reset:
  - rst for 3 clks with clk_en=1 → noise_rst=1, outputs 0, busy=0.
  - Release with sound_enable=1 → noise_rst=0 one clk later.
- Loud shell decay (NOISE_DIV=4, DECAY_DIV=8):
  - shell_trig 0→1 with shell_loud=1, shell_noise tied 1 → shell_out=15 two clks after edge.
  - Output steps 14..0 every 8 clk_en ticks; busy[0] drops at 0.
  - noise_en pulses every 4th tick while busy.
- Retrigger and simultaneity:
  - Shell at level 3, shell_loud=0, new edge → level 8.
  - Simultaneous shell/explo edges → both busy same cycle.
  - Edge on the prescaler-wrap cycle → reload, no decrement.
- Disable mid-effect:
  - Drop sound_enable at level 10 → level 0, busy 0, noise_rst=1 next clk.
  - Re-enable with trig held high → no restart.
- clk_en gating: clk_en=1 every 3rd clk → envelope and noise timing stretch 3×, noise_en width still 1 clk.
- Noise gating: explo_noise toggling, explo_loud=0 → explo_out alternates 0 and current level, one clk behind the input.
